// File: rtl/div_seq_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam int unsigned DEF_N = 4;
  localparam int unsigned DEF_M = 2;

  // The step counter must be able to hold the values 0..n.
  function automatic int unsigned step_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned DEF_STEP_W = step_w(DEF_N);

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_restoring_step #(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] divisor,
  input  logic         next_bit,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W-1:0] shifted_s;
  logic [W-1:0] diff_s;

  // The remainder stays below the divisor, so its MSB is always clear before the shift.
  always_comb begin
    shifted_s = {rem[W-2:0], next_bit};
    diff_s    = shifted_s - divisor;
    rem_next  = shifted_s;
    q_bit     = 1'b0;
    if (shifted_s >= divisor) begin
      rem_next = diff_s;
      q_bit    = 1'b1;
    end else begin
      rem_next = shifted_s;
      q_bit    = 1'b0;
    end
  end

endmodule

// File: rtl/n4by2_b2_seq_integer_divider.sv
// Multi-cycle Euclidean divider (N-bit dividend / M-bit divisor) with soc/eoc handshake.
// Define DIV_SOC_ABORT_EN to let soc restart an operation that is still in progress.
module n4by2_b2_seq_integer_divider
  import div_seq_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned M = DEF_M
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         soc,
  input  logic [N-1:0] x3_x0,
  input  logic [M-1:0] y1_y0,
  output logic         eoc,
  output logic [M-1:0] q1_q0,
  output logic [M-1:0] r1_r0,
  output logic         no_idiv
);

  localparam int unsigned CW = step_w(N);
  localparam int unsigned QW = N + 2;
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);
  localparam logic [CW-1:0] STEP_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic signed [QW-1:0] Q_ONE = {{(QW-1){1'b0}}, 1'b1};
  localparam logic signed [QW-1:0] Q_MAX = {{(QW-M+1){1'b0}}, {(M-1){1'b1}}};
  localparam logic signed [QW-1:0] Q_MIN = {{(QW-M+1){1'b1}}, {(M-1){1'b0}}};

  div_state_e      state_r;
  logic [CW-1:0]   step_r;
  logic            fix_stage_r;
  logic [N-1:0]    dvd_r;
  logic [M:0]      rem_r;
  logic [M-1:0]    ay_r;
  logic            sx_r;
  logic            sy_r;
  logic            yz_r;
  logic [M-1:0]    q_fix_r;
  logic [M-1:0]    r_fix_r;
  logic            bad_fix_r;

  logic            start_s;
  logic [N-1:0]    ax_s;
  logic [M-1:0]    ay_s;
  logic [M:0]      rem_step_s;
  logic            q_bit_s;
  logic signed [QW-1:0] qm_s;
  logic signed [QW-1:0] q_s;
  logic [M-1:0]    r_s;
  logic            bad_s;

`ifdef DIV_SOC_ABORT_EN
  assign start_s = soc;
`else
  assign start_s = soc && (state_r == IDLE);
`endif

  // Operand magnitudes; the most negative value maps onto the unsigned range without overflow.
  always_comb begin
    ax_s = x3_x0;
    ay_s = y1_y0;
    if (x3_x0[N-1]) begin
      ax_s = ~x3_x0 + {{(N-1){1'b0}}, 1'b1};
    end else begin
      ax_s = x3_x0;
    end
    if (y1_y0[M-1]) begin
      ay_s = ~y1_y0 + {{(M-1){1'b0}}, 1'b1};
    end else begin
      ay_s = y1_y0;
    end
  end

  div_restoring_step #(.W(M + 1)) u_step (
    .rem      (rem_r),
    .divisor  ({1'b0, ay_r}),
    .next_bit (dvd_r[N-1]),
    .rem_next (rem_step_s),
    .q_bit    (q_bit_s)
  );

  // Sign and Euclidean correction of the magnitude result, plus the range check.
  always_comb begin
    qm_s = {2'b00, dvd_r};
    q_s  = qm_s;
    r_s  = rem_r[M-1:0];
    if (sx_r ^ sy_r) begin
      q_s = -qm_s;
    end else begin
      q_s = qm_s;
    end
    if (sx_r && (rem_r != {(M+1){1'b0}})) begin
      r_s = ay_r - rem_r[M-1:0];
      if (sy_r) begin
        q_s = q_s + Q_ONE;
      end else begin
        q_s = q_s - Q_ONE;
      end
    end else begin
      r_s = rem_r[M-1:0];
    end
    bad_s = yz_r || (q_s > Q_MAX) || (q_s < Q_MIN);
  end

  // Control FSM: operand capture, N restoring steps, two-cycle fix-up and output load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      step_r      <= {CW{1'b0}};
      fix_stage_r <= 1'b0;
      dvd_r       <= {N{1'b0}};
      rem_r       <= {(M+1){1'b0}};
      ay_r        <= {M{1'b0}};
      sx_r        <= 1'b0;
      sy_r        <= 1'b0;
      yz_r        <= 1'b0;
      q_fix_r     <= {M{1'b0}};
      r_fix_r     <= {M{1'b0}};
      bad_fix_r   <= 1'b0;
      eoc         <= 1'b1;
      q1_q0       <= {M{1'b0}};
      r1_r0       <= {M{1'b0}};
      no_idiv     <= 1'b0;
    end else if (start_s) begin
      state_r     <= DIV;
      step_r      <= {CW{1'b0}};
      fix_stage_r <= 1'b0;
      dvd_r       <= ax_s;
      rem_r       <= {(M+1){1'b0}};
      ay_r        <= ay_s;
      sx_r        <= x3_x0[N-1];
      sy_r        <= y1_y0[M-1];
      yz_r        <= (y1_y0 == {M{1'b0}});
      eoc         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        DIV: begin
          // Quotient bits enter at the LSB as dividend bits leave at the MSB.
          dvd_r  <= {dvd_r[N-2:0], q_bit_s};
          rem_r  <= rem_step_s;
          step_r <= step_r + STEP_ONE;
          if (step_r == LAST_STEP) begin
            state_r     <= FIX;
            fix_stage_r <= 1'b0;
          end else begin
            state_r <= DIV;
          end
        end
        FIX: begin
          if (!fix_stage_r) begin
            q_fix_r     <= bad_s ? {M{1'b0}} : q_s[M-1:0];
            r_fix_r     <= bad_s ? {M{1'b0}} : r_s;
            bad_fix_r   <= bad_s;
            fix_stage_r <= 1'b1;
          end else begin
            q1_q0       <= q_fix_r;
            r1_r0       <= r_fix_r;
            no_idiv     <= bad_fix_r;
            eoc         <= 1'b1;
            fix_stage_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          eoc     <= 1'b1;
        end
      endcase
    end
  end

endmodule
